send_scheduler: RTL

- Periodic transmit scheduler for the two MAC send-packet control interfaces (cmd_send + start_ram_addr per channel).
- Replaces the free-running counter in the top level.
- Runs one period counter per channel, arbitrates round-robin when both channels are due, and issues fixed-width cmd_send pulses separated by a guard gap.
- Reports per-channel sent and overrun counts for status LEDs and debug.

---
 rtl/send_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/send_scheduler.sv
// send_scheduler: periodic round-robin cmd_send scheduler for two MAC send channels.
module send_scheduler #(
  parameter int PERIOD_1  = 255,
  parameter int PERIOD_2  = 511,
  parameter int CMD_WIDTH = 3,
  parameter int GAP       = 8,
  parameter int ADDR_W    = 25
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        ch_en,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  output logic              cmd_send_1,
  output logic              cmd_send_2,
  output logic [ADDR_W-1:0] start_ram_addr_1,
  output logic [ADDR_W-1:0] start_ram_addr_2,
  output logic              busy,
  output logic [15:0]       sent_cnt_1,
  output logic [15:0]       sent_cnt_2,
  output logic [7:0]        overrun_cnt_1,
  output logic [7:0]        overrun_cnt_2
);
  localparam int PMAX = PERIOD_1 > PERIOD_2 ? PERIOD_1 : PERIOD_2;
  localparam int PW = $clog2(PMAX);
  localparam int TW = $clog2(CMD_WIDTH + GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic sel, sel_n, ptr, cmd_1_n, cmd_2_n, busy_n;
  logic [1:0] act, due, pend, gnt, req;
  logic [PW-1:0] pc [2];
  logic [15:0] sent [2];
  logic [7:0] ovr [2];
  logic [ADDR_W-1:0] addr_q [2];
  assign act = {en & ch_en[1], en & ch_en[0]};
  assign due = {act[1] && pc[1] == PW'(PERIOD_2 - 1), act[0] && pc[0] == PW'(PERIOD_1 - 1)};
  assign req = pend & act;
  // ptr = 0 favours channel 1 on a tie
  assign gnt[0] = state == S_IDLE && req[0] && !(req[1] && ptr);
  assign gnt[1] = state == S_IDLE && req[1] && !(req[0] && !ptr);
  always_ff @(posedge clk_50)
    if (reset) begin
      state <= S_IDLE;
      tcnt <= '0;
      sel <= 1'b0;
      cmd_send_1 <= 1'b0;
      cmd_send_2 <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      sel <= sel_n;
      cmd_send_1 <= cmd_1_n;
      cmd_send_2 <= cmd_2_n;
      busy <= busy_n;
    end
  always_comb begin
    state_n = state == S_IDLE ? (|gnt ? S_ASSERT : S_IDLE) :
              state == S_ASSERT ? (tcnt == TW'(CMD_WIDTH - 1) ? (GAP == 0 ? S_IDLE : S_GAP) : S_ASSERT) :
              (tcnt == TW'(GAP - 1) ? S_IDLE : S_GAP);
    tcnt_n = (state == S_IDLE || state_n != state) ? '0 : tcnt + 1'b1;
  end
  always_comb begin
    sel_n = gnt[1] ? 1'b1 : gnt[0] ? 1'b0 : sel;
    cmd_1_n = state_n == S_ASSERT && !sel_n;
    cmd_2_n = state_n == S_ASSERT && sel_n;
    busy_n = state_n != S_IDLE;
  end
  always_ff @(posedge clk_50)
    if (reset) begin
      pc <= '{default: '0};
      pend <= '0;
      ptr <= 1'b0;
      sent <= '{default: '0};
      ovr <= '{default: '0};
      addr_q <= '{default: '0};
    end else begin
      if (req == 2'b11 && |gnt) ptr <= gnt[0];
      for (int i = 0; i < 2; i++) begin
        pc[i] <= (!act[i] || due[i]) ? '0 : pc[i] + 1'b1;
        // a due coinciding with a grant re-arms pending rather than counting as an overrun
        pend[i] <= act[i] && (due[i] || (pend[i] && !gnt[i]));
        if (due[i] && pend[i] && !gnt[i] && ovr[i] != 8'hff) ovr[i] <= ovr[i] + 8'd1;
        if (gnt[i]) begin
          sent[i] <= sent[i] + 16'd1;
          addr_q[i] <= i == 0 ? addr_1 : addr_2;
        end
      end
    end
  assign sent_cnt_1 = sent[0];
  assign sent_cnt_2 = sent[1];
  assign overrun_cnt_1 = ovr[0];
  assign overrun_cnt_2 = ovr[1];
  assign start_ram_addr_1 = addr_q[0];
  assign start_ram_addr_2 = addr_q[1];
endmodule
